bullet_controller: RTL and testbench



---
 rtl/bullet_controller.sv | 214 +++++++++++++++++++++
 tb/tb_bullet_controller.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bullet_controller.sv
// Per-player bullet: spawns at the tank muzzle on a fire edge, moves once per frame,
// despawns on hit or playfield exit. Optional macro BULLET_WALL_BOUNCE_EN reflects off walls.
module bullet_controller #(
  parameter int BULLET_SPEED    = 4,
  parameter int BULLET_SIZE     = 2,
  parameter int MUZZLE_OFFSET   = 12,
  parameter int X_MIN           = 0,
  parameter int X_MAX           = 639,
  parameter int Y_MIN           = 0,
  parameter int Y_MAX           = 479,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       fire,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [1:0] direction,
  input  logic       barrier_hit,
  input  logic       tank_hit,
  output logic [9:0] BulletX,
  output logic [9:0] BulletY,
  output logic [9:0] Bullet_Size,
  output logic       bullet_active,
  output logic       score_pulse,
  output logic [1:0] state_dbg
);

  // Handshake: none. fire is a level sampled every frame; a rising edge is a request,
  // accepted only in IDLE. Hit flags are single-frame qualifiers, honoured only in FLYING.

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLYING   = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  // Arithmetic is 12-bit signed: wide enough for 1023 + MUZZLE_OFFSET and for 0 - speed.
  localparam logic signed [11:0] SPEED_S  = 12'(BULLET_SPEED);
  localparam logic signed [11:0] OFFSET_S = 12'(MUZZLE_OFFSET);
  localparam logic signed [11:0] X_MIN_S  = 12'(X_MIN);
  localparam logic signed [11:0] X_MAX_S  = 12'(X_MAX);
  localparam logic signed [11:0] Y_MIN_S  = 12'(Y_MIN);
  localparam logic signed [11:0] Y_MAX_S  = 12'(Y_MAX);
  localparam logic [9:0]         SIZE_V   = 10'(BULLET_SIZE);

  localparam int CD_LOAD = (COOLDOWN_FRAMES == 0) ? 0 : COOLDOWN_FRAMES - 1;
  localparam int CW      = (CD_LOAD < 2) ? 1 : $clog2(CD_LOAD + 1);
  localparam logic [CW-1:0] CD_LOAD_V = CW'(CD_LOAD);

  function automatic logic signed [11:0] axis_dx(input logic [1:0] d,
                                                 input logic signed [11:0] m);
    case (d)
      2'd1:    axis_dx = m;
      2'd3:    axis_dx = -m;
      default: axis_dx = '0;
    endcase
  endfunction

  function automatic logic signed [11:0] axis_dy(input logic [1:0] d,
                                                 input logic signed [11:0] m);
    case (d)
      2'd0:    axis_dy = -m;
      2'd2:    axis_dy = m;
      default: axis_dy = '0;
    endcase
  endfunction

  function automatic logic in_field(input logic signed [11:0] x,
                                    input logic signed [11:0] y);
    in_field = (x >= X_MIN_S) && (x <= X_MAX_S) && (y >= Y_MIN_S) && (y <= Y_MAX_S);
  endfunction

`ifdef BULLET_WALL_BOUNCE_EN
  function automatic logic [9:0] clamp10(input logic signed [11:0] v,
                                         input logic signed [11:0] lo,
                                         input logic signed [11:0] hi);
    logic signed [11:0] r;
    if (v < lo)      r = lo;
    else if (v > hi) r = hi;
    else             r = v;
    clamp10 = r[9:0];
  endfunction
`endif

  state_t            state, state_nx;
  logic              fire_q;
  logic              fire_rise;
  logic [1:0]        dir_q, dir_nx;
  logic [9:0]        x_nx, y_nx, size_nx;
  logic              active_nx, score_nx;
  logic [CW-1:0]     cd_cnt, cd_nx;
  logic              despawn;
  logic signed [11:0] spawn_x, spawn_y, move_x, move_y;
  logic              spawn_ok, move_ok;
`ifdef BULLET_WALL_BOUNCE_EN
  logic [1:0]        bounce_cnt, bounce_nx;
`endif

  assign fire_rise = fire & ~fire_q;
  assign state_dbg = state;

  assign spawn_x  = $signed({2'b00, TankX}) + axis_dx(direction, OFFSET_S);
  assign spawn_y  = $signed({2'b00, TankY}) + axis_dy(direction, OFFSET_S);
  assign spawn_ok = in_field(spawn_x, spawn_y);

  assign move_x  = $signed({2'b00, BulletX}) + axis_dx(dir_q, SPEED_S);
  assign move_y  = $signed({2'b00, BulletY}) + axis_dy(dir_q, SPEED_S);
  assign move_ok = in_field(move_x, move_y);

  always_comb begin
    state_nx  = state;
    x_nx      = BulletX;
    y_nx      = BulletY;
    size_nx   = Bullet_Size;
    active_nx = bullet_active;
    score_nx  = 1'b0;
    dir_nx    = dir_q;
    cd_nx     = cd_cnt;
    despawn   = 1'b0;
`ifdef BULLET_WALL_BOUNCE_EN
    bounce_nx = bounce_cnt;
`endif

    case (state)
      S_IDLE: begin
        if (fire_rise && spawn_ok) begin
          state_nx  = S_FLYING;
          x_nx      = spawn_x[9:0];
          y_nx      = spawn_y[9:0];
          size_nx   = SIZE_V;
          active_nx = 1'b1;
          dir_nx    = direction;
`ifdef BULLET_WALL_BOUNCE_EN
          bounce_nx = 2'd0;
`endif
        end
      end

      S_FLYING: begin
        // A simultaneous barrier hit still scores: the tank hit wins.
        if (tank_hit) begin
          despawn  = 1'b1;
          score_nx = 1'b1;
        end else if (barrier_hit) begin
          despawn = 1'b1;
        end else if (move_ok) begin
          x_nx = move_x[9:0];
          y_nx = move_y[9:0];
        end else begin
`ifdef BULLET_WALL_BOUNCE_EN
          if (bounce_cnt == 2'd3) begin
            despawn = 1'b1;
          end else begin
            x_nx      = clamp10(move_x, X_MIN_S, X_MAX_S);
            y_nx      = clamp10(move_y, Y_MIN_S, Y_MAX_S);
            dir_nx    = dir_q ^ 2'b10;
            bounce_nx = bounce_cnt + 2'd1;
          end
`else
          despawn = 1'b1;
`endif
        end
      end

      S_COOLDOWN: begin
        if (cd_cnt == '0) state_nx = S_IDLE;
        else              cd_nx    = cd_cnt - CW'(1);
      end

      default: state_nx = S_IDLE;
    endcase

    if (despawn) begin
      state_nx  = S_COOLDOWN;
      x_nx      = '0;
      y_nx      = '0;
      size_nx   = '0;
      active_nx = 1'b0;
      cd_nx     = CD_LOAD_V;
    end
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state         <= S_IDLE;
      fire_q        <= 1'b0;
      dir_q         <= 2'd0;
      BulletX       <= '0;
      BulletY       <= '0;
      Bullet_Size   <= '0;
      bullet_active <= 1'b0;
      score_pulse   <= 1'b0;
      cd_cnt        <= '0;
`ifdef BULLET_WALL_BOUNCE_EN
      bounce_cnt    <= 2'd0;
`endif
    end else begin
      state         <= state_nx;
      fire_q        <= fire;
      dir_q         <= dir_nx;
      BulletX       <= x_nx;
      BulletY       <= y_nx;
      Bullet_Size   <= size_nx;
      bullet_active <= active_nx;
      score_pulse   <= score_nx;
      cd_cnt        <= cd_nx;
`ifdef BULLET_WALL_BOUNCE_EN
      bounce_cnt    <= bounce_nx;
`endif
    end
  end

endmodule

// File: tb/tb_bullet_controller.sv
// Bench for bullet_controller: directed scenarios plus random frames, all checked
// against a frame-level model of the bullet's life (spawn, move, hit, exit, cooldown).
module tb_bullet_controller;

  localparam int COOL = 15;

  logic       frame_clk = 1'b0;
  logic       Reset_n, fire, barrier_hit, tank_hit;
  logic [9:0] TankX, TankY;
  logic [1:0] direction;
  logic [9:0] BulletX, BulletY, Bullet_Size;
  logic       bullet_active, score_pulse;
  logic [1:0] state_dbg;

  bullet_controller dut (
    .frame_clk    (frame_clk),
    .Reset_n      (Reset_n),
    .fire         (fire),
    .TankX        (TankX),
    .TankY        (TankY),
    .direction    (direction),
    .barrier_hit  (barrier_hit),
    .tank_hit     (tank_hit),
    .BulletX      (BulletX),
    .BulletY      (BulletY),
    .Bullet_Size  (Bullet_Size),
    .bullet_active(bullet_active),
    .score_pulse  (score_pulse),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 frame_clk = ~frame_clk;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  // reference model: one bullet, cooldown as frames-remaining
  int m_x, m_y, m_dir, m_cool, m_bounce;
  bit m_active, m_score, m_fire_prev;

  function automatic int sx_of(int d);
    return (d == 1) ? 1 : (d == 3) ? -1 : 0;
  endfunction

  function automatic int sy_of(int d);
    return (d == 2) ? 1 : (d == 0) ? -1 : 0;
  endfunction

  function automatic bit on_field(int x, int y);
    return (x >= 0) && (x <= 639) && (y >= 0) && (y <= 479);
  endfunction

  function automatic int clampi(int v, int lo, int hi);
    return (v < lo) ? lo : (v > hi) ? hi : v;
  endfunction

  function automatic void model_despawn(bit scored);
    m_active = 0;
    m_x      = 0;
    m_y      = 0;
    m_score  = scored;
    m_cool   = (COOL == 0) ? 1 : COOL;
  endfunction

  function automatic void model_edge();
    bit rise;
    int nx, ny;
    rise    = fire && !m_fire_prev;
    m_score = 0;
    if (!Reset_n) begin
      m_active = 0; m_x = 0; m_y = 0; m_dir = 0;
      m_cool = 0; m_bounce = 0; m_fire_prev = 0;
      return;
    end
    if (m_active) begin
      if (tank_hit)         model_despawn(1);
      else if (barrier_hit) model_despawn(0);
      else begin
        nx = m_x + 4 * sx_of(m_dir);
        ny = m_y + 4 * sy_of(m_dir);
        if (on_field(nx, ny)) begin
          m_x = nx;
          m_y = ny;
        end
`ifdef BULLET_WALL_BOUNCE_EN
        else if (m_bounce < 3) begin
          m_x      = clampi(nx, 0, 639);
          m_y      = clampi(ny, 0, 479);
          m_dir    = (m_dir + 2) % 4;
          m_bounce = m_bounce + 1;
        end
`endif
        else model_despawn(0);
      end
    end else if (m_cool > 0) begin
      m_cool = m_cool - 1;
    end else if (rise) begin
      nx = int'(TankX) + 12 * sx_of(int'(direction));
      ny = int'(TankY) + 12 * sy_of(int'(direction));
      if (on_field(nx, ny)) begin
        m_active = 1; m_x = nx; m_y = ny;
        m_dir = int'(direction); m_bounce = 0;
      end
    end
    m_fire_prev = fire;
  endfunction

  function automatic logic [31:0] model_pack();
    return {10'(m_x), 10'(m_y), (m_active ? 10'd2 : 10'd0), m_active, m_score};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input string tag);
    logic [31:0] e;
    @(posedge frame_clk);
    model_edge();
    exp_q.push_back(model_pack());
    #1;
    e = exp_q.pop_front();
    check(tag, {BulletX, BulletY, Bullet_Size, bullet_active, score_pulse}, e);
  endtask

  task automatic aim(input int tx, input int ty, input int d);
    TankX     = 10'(tx);
    TankY     = 10'(ty);
    direction = 2'(d);
  endtask

  task automatic kill_and_wait();
    fire = 1'b0; tank_hit = 1'b0; barrier_hit = 1'b1;
    tick("kill");
    barrier_hit = 1'b0;
    repeat (16) tick("settle");
  endtask

  initial begin
    Reset_n = 1'b0; fire = 1'b0; barrier_hit = 1'b0; tank_hit = 1'b0;
    aim(100, 200, 1);
    m_x = 0; m_y = 0; m_dir = 0; m_cool = 0; m_bounce = 0;
    m_active = 0; m_score = 0; m_fire_prev = 0;

    repeat (2) tick("reset");
    check("reset_outs", 32'({BulletX, BulletY, Bullet_Size, bullet_active, score_pulse}), 32'd0);
    Reset_n = 1'b1;

    // spawn to the right, one move, direction change ignored
    tick("idle");
    fire = 1'b1; tick("spawn");
    check("spawn_x", 32'(BulletX), 32'd112);
    check("spawn_y", 32'(BulletY), 32'd200);
    check("spawn_size", 32'(Bullet_Size), 32'd2);
    fire = 1'b0; tick("move1");
    check("move1_x", 32'(BulletX), 32'd116);
    direction = 2'd0; tick("move2");
    check("dir_ignored_x", 32'(BulletX), 32'd120);

    // tank and barrier together: one score pulse
    tank_hit = 1'b1; barrier_hit = 1'b1; tick("dual_hit");
    check("dual_score", 32'(score_pulse), 32'd1);
    check("dual_active", 32'(bullet_active), 32'd0);
    tank_hit = 1'b0; barrier_hit = 1'b0; tick("after_hit");
    check("score_one_frame", 32'(score_pulse), 32'd0);
    repeat (14) tick("cool");
    aim(312, 100, 3);
    fire = 1'b1; tick("respawn");
    check("respawn_x", 32'(BulletX), 32'd300);

    // barrier hit, early fire discarded, later fire accepted
    fire = 1'b0; barrier_hit = 1'b1; tick("barrier");
    check("barrier_score", 32'(score_pulse), 32'd0);
    check("barrier_size", 32'(Bullet_Size), 32'd0);
    barrier_hit = 1'b0;
    repeat (4) tick("cool");
    fire = 1'b1; tick("early_fire");
    check("early_fire_ignored", 32'(bullet_active), 32'd0);
    fire = 1'b0;
    repeat (10) tick("cool");
    fire = 1'b1; tick("late_fire");
    check("late_fire_spawn", 32'(bullet_active), 32'd1);

    // fire held through cooldown
    fire = 1'b0; barrier_hit = 1'b1; tick("barrier2");
    barrier_hit = 1'b0; fire = 1'b1;
    repeat (20) tick("held");
    check("held_no_shot", 32'(bullet_active), 32'd0);
    fire = 1'b0; tick("release");
    fire = 1'b1; tick("rearm");
    check("rearm_spawn", 32'(bullet_active), 32'd1);

    // upward to the top edge, no wrap
    kill_and_wait();
    aim(50, 20, 0);
    fire = 1'b1; tick("up_spawn");
    check("up_y8", 32'(BulletY), 32'd8);
    fire = 1'b0; tick("up1");
    check("up_y4", 32'(BulletY), 32'd4);
    tick("up2");
    check("up_y0", 32'(BulletY), 32'd0);
    tick("up_exit");
`ifndef BULLET_WALL_BOUNCE_EN
    check("top_exit_active", 32'(bullet_active), 32'd0);
    check("top_exit_y", 32'(BulletY), 32'd0);
`endif

    // spawn point off the field
    kill_and_wait();
    aim(5, 100, 3);
    fire = 1'b1; tick("off_spawn");
    check("off_spawn_idle", 32'(bullet_active), 32'd0);
    fire = 1'b0; tick("off_idle");

    // reset mid-flight
    aim(300, 300, 2);
    fire = 1'b1; tick("rst_spawn");
    fire = 1'b0; tick("rst_move");
    Reset_n = 1'b0; tick("rst_mid");
    check("rst_mid_outs", 32'({BulletX, BulletY, Bullet_Size, bullet_active, score_pulse}), 32'd0);
    Reset_n = 1'b1; tick("rst_release");

`ifdef BULLET_WALL_BOUNCE_EN
    aim(620, 100, 1);
    fire = 1'b1; tick("b_spawn");
    fire = 1'b0; tick("b_move");
    tick("b_clamp");
    check("bounce_clamp_x", 32'(BulletX), 32'd639);
    tick("b_back");
    check("bounce_left_x", 32'(BulletX), 32'd635);
    repeat (600) tick("b_fly");
    check("bounce_4th_exit", 32'(bullet_active), 32'd0);
`endif

    // random frames
    for (int i = 0; i < 3000; i++) begin
      Reset_n = ($urandom_range(0, 399) != 0);
      if ($urandom_range(0, 3) == 0) fire = ~fire;
      if ($urandom_range(0, 39) == 0) aim($urandom_range(0, 1023), $urandom_range(0, 1023),
                                          $urandom_range(0, 3));
      else if ($urandom_range(0, 7) == 0) direction = 2'($urandom_range(0, 3));
      barrier_hit = ($urandom_range(0, 29) == 0);
      tank_hit    = ($urandom_range(0, 39) == 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
